// File: rtl/rv_alu_if.sv
// Operand/result bundle between the execute stage and the ALU.
interface rv_alu_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       alu_control_i;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] alu_result_o;
    logic             N;
    logic             Z;
    logic             C;
    logic             V;
    logic [3:0]       flags_q_o;

    modport master (
        output alu_control_i, A, B,
        input  alu_result_o, N, Z, C, V, flags_q_o
    );

    modport slave (
        input  alu_control_i, A, B,
        output alu_result_o, N, Z, C, V, flags_q_o
    );
endinterface

// File: rtl/rv_alu.sv
// RV32I execute-stage ALU: zero-latency result and NZCV flags, no flow control.
// Only the debug flag snapshot is clocked (one cycle behind the flags).
module rv_alu #(
    parameter int WIDTH = 32
) (
    input  logic         clk_i,
    input  logic         reset_i,
    rv_alu_if.slave      bus
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
    logic [3:0]       flags_q;

    assign shamt = bus.B[4:0];
    // SUB is built as A + ~B + 1 so the carry out doubles as "no borrow".
    assign sum_add = {1'b0, bus.A} + {1'b0, bus.B};
    assign sum_sub = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (bus.alu_control_i)
            OP_ADD: begin
                result = sum_add[WIDTH-1:0];
                carry  = sum_add[WIDTH];
                ovf    = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                         (sum_add[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                result = sum_sub[WIDTH-1:0];
                carry  = sum_sub[WIDTH];
                ovf    = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                         (sum_sub[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND:  result = bus.A & bus.B;
            OP_OR:   result = bus.A | bus.B;
            OP_XOR:  result = bus.A ^ bus.B;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            OP_SLL:  result = bus.A << shamt;
            OP_SRL:  result = bus.A >> shamt;
            OP_SRA:  result = $unsigned($signed(bus.A) >>> shamt);
            default: result = '0;
        endcase
    end

    assign bus.alu_result_o = result;
    assign bus.N            = result[WIDTH-1];
    assign bus.Z            = (result == '0);
    assign bus.C            = carry;
    assign bus.V            = ovf;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= {result[WIDTH-1], (result == '0), carry, ovf};
        end
    end

    assign bus.flags_q_o = flags_q;
endmodule

// File: tb/tb_rv_alu.sv
// Bench for rv_alu: directed vector table, flag-register sequence, random ops vs. arithmetic model.
module tb_rv_alu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    rv_alu_if #(.WIDTH(32)) bus ();

    rv_alu #(.WIDTH(32)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  nzcv;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] dut_out();
        return {bus.N, bus.Z, bus.C, bus.V, bus.alu_result_o};
    endfunction

    // Reference built from signed/unsigned integer arithmetic rather than bit tricks.
    function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        c;
        logic        v;
        longint      sa;
        longint      sb;
        longint      s;
        logic [4:0]  sh;
        r  = '0;
        c  = 1'b0;
        v  = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = b[4:0];
        case (op)
            4'd0: begin
                r = a + b;
                c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd6: r = (a < b) ? 32'd1 : 32'd0;
            4'd7: r = a << sh;
            4'd8: r = a >> sh;
            4'd9: r = $unsigned($signed(a) >>> sh);
            default: r = '0;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.alu_control_i = op;
        bus.A = a;
        bus.B = b;
        #1;
    endtask

    initial begin
        logic [35:0] exp;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0]  = '{"add_ovf",  4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001};
        vecs[1]  = '{"add_wrap", 4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110};
        vecs[2]  = '{"sub_eq",   4'b0001, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110};
        vecs[3]  = '{"sub_neg",  4'b0001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b1000};
        vecs[4]  = '{"sub_ovf",  4'b0001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
        vecs[5]  = '{"and",      4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000};
        vecs[6]  = '{"or",       4'b0011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 4'b1000};
        vecs[7]  = '{"xor",      4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 4'b1000};
        vecs[8]  = '{"slt",      4'b0101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000};
        vecs[9]  = '{"sltu",     4'b0110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0100};
        vecs[10] = '{"sll",      4'b0111, 32'h80000001, 32'h00000024, 32'h00000010, 4'b0000};
        vecs[11] = '{"srl",      4'b1000, 32'h80000001, 32'h00000024, 32'h08000000, 4'b0000};
        vecs[12] = '{"sra",      4'b1001, 32'h80000001, 32'h00000024, 32'hF8000000, 4'b1000};
        vecs[13] = '{"unused_f", 4'b1111, 32'h80000001, 32'h00000024, 32'h00000000, 4'b0100};
        vecs[14] = '{"unused_a", 4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0100};
        vecs[15] = '{"slt_pos",  4'b0101, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 4'b0100};

        rst = 1'b1;
        apply(4'b0000, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("reset_flags", {32'h0, bus.flags_q_o}, 36'h0);

        // Combinational outputs must ignore reset.
        apply(vecs[0].op, vecs[0].a, vecs[0].b);
        check("comb_in_reset", dut_out(), {vecs[0].nzcv, vecs[0].res});

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check(vecs[i].name, dut_out(), {vecs[i].nzcv, vecs[i].res});
        end

        @(negedge clk);
        rst = 1'b0;
        apply(4'b0000, 32'h7FFFFFFF, 32'h00000001);
        @(posedge clk);
        #1;
        check("flags_q_load", {32'h0, bus.flags_q_o}, {32'h0, 4'b1001});
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("flags_q_rst", {32'h0, bus.flags_q_o}, 36'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            op = 4'($urandom_range(0, 15));
            a  = $urandom();
            b  = $urandom();
            case ($urandom_range(0, 5))
                0: a = 32'h80000000;
                1: b = 32'h7FFFFFFF;
                2: b = a;
                default: ;
            endcase
            apply(op, a, b);
            exp = model(op, a, b);
            check("rand_comb", dut_out(), exp);
            @(posedge clk);
            #1;
            check("rand_flags_q", {32'h0, bus.flags_q_o}, {32'h0, exp[35:32]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rv_alu.md
Name: rv_alu

Overview:
- 32-bit integer ALU for the execute stage of the RV32I pipelined core.
- Combinationally computes a result and N/Z/C/V flags from two operands and a 4-bit operation select.
- The branch unit consumes N/Z/C/V from a SUB operation to resolve conditional branches.
- A registered copy of the flags is kept for debug/observation. It is the only clocked logic.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported; flag rules below assume bit 31 is the MSB.

Ports:
- clk_i  input  1  clock; clocks only the flag snapshot register
- reset_i  input  1  synchronous, active-high reset
- alu_control_i  input  4  operation select
- A  input  32  operand A (rs1 or PC)
- B  input  32  operand B (rs2 or immediate)
- alu_result_o  output  32  operation result, combinational
- N  output  1  negative flag, combinational
- Z  output  1  zero flag, combinational
- C  output  1  carry flag, combinational
- V  output  1  signed overflow flag, combinational
- flags_q_o  output  4  registered {N,Z,C,V} from the previous cycle

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- alu_result_o, N, Z, C and V are purely combinational from alu_control_i, A and B.
  - Zero latency; no clock dependence.
  - Valid within the same delta/settle time as the inputs.
- alu_control_i encoding:
  - 0000 ADD: A + B, modulo 2^32
  - 0001 SUB: A - B, implemented as A + ~B + 1
  - 0010 AND: A & B
  - 0011 OR: A | B
  - 0100 XOR: A ^ B
  - 0101 SLT: 1 if $signed(A) < $signed(B), else 0 (zero-extended to 32 bits)
  - 0110 SLTU: 1 if A < B unsigned, else 0
  - 0111 SLL: A << B[4:0]
  - 1000 SRL: A >> B[4:0], zero fill
  - 1001 SRA: A >>> B[4:0], sign fill from A[31]
  - 1010-1111: result 32'h0
- Shifts use only B[4:0]; B[31:5] is ignored.
- N = alu_result_o[31] for every operation.
- Z = (alu_result_o == 0) for every operation, including unused codes (Z=1 there).
- C:
  - ADD: carry-out of bit 31 of A+B.
  - SUB: carry-out of A + ~B + 1. C=1 means no borrow (A >= B unsigned); A == B gives C=1.
  - All other operations: C = 0.
- V:
  - ADD: set when A[31]==B[31] and result[31]!=A[31].
  - SUB: set when A[31]!=B[31] and result[31]!=A[31].
  - All other operations: V = 0.
- flags_q_o:
  - On each rising clk_i edge, loads {N,Z,C,V}.
  - If reset_i=1 at the edge, loads 4'b0000 instead; reset has priority.
  - Reset value is 4'b0000.
  - Reset does not affect the combinational outputs.
- No X-propagation tricks: every output is defined for every input combination.

Test Plan:
- ADD overflow/carry: ctrl=0000, A=32'h7FFFFFFF, B=1 -> result 32'h80000000, N=1 Z=0 C=0 V=1. Then A=32'hFFFFFFFF, B=1 -> result 0, N=0 Z=1 C=1 V=0.
- SUB: ctrl=0001, A=5, B=5 -> result 0, Z=1 C=1 V=0 N=0. A=3, B=5 -> result 32'hFFFFFFFE, N=1 C=0 V=0. A=32'h80000000, B=1 -> result 32'h7FFFFFFF, V=1 C=1 N=0.
- Logic ops: A=32'hF0F0F0F0, B=32'h0FF00FF0:
  - AND -> 32'h00F000F0
  - OR -> 32'hFFF0FFF0
  - XOR -> 32'hFF00FF00
  - C=0 and V=0 in all three.
- Compares: A=32'hFFFFFFFF, B=1:
  - SLT -> 1, Z=0
  - SLTU -> 0, Z=1, N=0
- Shifts: A=32'h80000001, B=32'h00000024 (amount 4):
  - SLL -> 32'h00000010
  - SRL -> 32'h08000000
  - SRA -> 32'hF8000000, N=1
  - Unused code 1111 -> result 0, Z=1
- Flag register: hold reset_i=1 for one edge -> flags_q_o=0000. Release, apply the ADD overflow vector -> flags_q_o=4'b1001 after the next edge. Assert reset_i -> 0000 at the following edge.
